// File: rtl/legendre_rom_arbiter_if.sv
// Requester-side bus of the Legendre ROM arbiter: per-requester address, read and
// urgent flags in one direction, grant and returned ROM data in the other.
interface legendre_rom_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    logic [10*NUM_REQ-1:0] req_addr;
    logic [NUM_REQ-1:0]    req_rd;
    logic [NUM_REQ-1:0]    req_preempt;
    logic [NUM_REQ-1:0]    req_read_valid;
    logic [NUM_REQ-1:0]    data_valid;
    logic [15:0]           legendre_data;

    // req_rd[i] stays high until req_read_valid[i] grants it in the same cycle; one cycle
    // later data_valid[i] marks legendre_data as requester i's word.
    modport master (
        output req_addr, req_rd, req_preempt,
        input  req_read_valid, data_valid, legendre_data
    );
    modport slave (
        input  req_addr, req_rd, req_preempt,
        output req_read_valid, data_valid, legendre_data
    );
endinterface

// File: rtl/legendre_rom_arbiter.sv
// Arbitrates Legendre-table reads from the Weil PRN generators onto one synchronous ROM,
// with host writes taking absolute priority and aged requests promoted to urgent.
module legendre_rom_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    legendre_rom_arbiter_if.slave bus,
    output logic [9:0]            rom_addr_o,
    output logic                  rom_rd_o,
    input  logic [15:0]           rom_rdata_i,
    input  logic                  host_wr_i,
    input  logic [9:0]            host_addr_i,
    input  logic [15:0]           host_wdata_i,
    output logic                  rom_wr_o,
    output logic [15:0]           rom_wdata_o,
    output logic                  addr_err_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [9:0] ADDR_MAX = 10'd640;

    logic [PW-1:0]      rr_q, rr_d;
    logic [WW-1:0]      wait_q [NUM_REQ];
    logic [WW-1:0]      wait_d [NUM_REQ];
    logic [NUM_REQ-1:0] dv_q;
    logic [9:0]         rom_addr_q;
    logic               addr_err_q, addr_err_d;

    logic [NUM_REQ-1:0] urgent, cand, grant;
    logic               grant_any;
    logic [PW-1:0]      gidx;
    logic [9:0]         gaddr;

    always_comb begin
        int          idx;
        logic [PW-1:0] idx_p;
        idx       = 0;
        idx_p     = '0;
        urgent    = '0;
        grant_any = 1'b0;
        gidx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            urgent[i] = bus.req_rd[i] && (bus.req_preempt[i] || wait_q[i] == WW'(MAX_WAIT));
        end
        // Urgent requests shadow normal ones; host writes and reset block every grant.
        cand = (|urgent) ? urgent : bus.req_rd;
        if (rst || host_wr_i) begin
            cand = '0;
        end
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = (int'(rr_q) + k) % NUM_REQ;
            idx_p = PW'(idx);
            if (!grant_any && cand[idx_p]) begin
                grant_any = 1'b1;
                gidx      = idx_p;
            end
        end
        grant = grant_any ? (NUM_REQ'(1) << gidx) : '0;
        gaddr = bus.req_addr[int'(gidx)*10 +: 10];
    end

    always_comb begin
        rom_rd_o = grant_any;
        if (host_wr_i) begin
            rom_addr_o = host_addr_i;
        end else if (grant_any) begin
            rom_addr_o = gaddr;
        end else begin
            rom_addr_o = rom_addr_q;
        end
    end

    always_comb begin
        rr_d       = grant_any ? gidx : rr_q;
        addr_err_d = addr_err_q || (grant_any && gaddr > ADDR_MAX);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_rd[i] && !grant[i]) begin
                wait_d[i] = (wait_q[i] == WW'(MAX_WAIT)) ? wait_q[i] : wait_q[i] + 1'b1;
            end else begin
                wait_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= PW'(NUM_REQ - 1);
            dv_q       <= '0;
            rom_addr_q <= '0;
            addr_err_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            dv_q       <= grant;
            rom_addr_q <= rom_addr_o;
            addr_err_q <= addr_err_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    // A grant followed by reset is discarded: its data_valid never reaches the requester.
    assign bus.req_read_valid = grant;
    assign bus.data_valid     = rst ? '0 : dv_q;
    assign bus.legendre_data  = rom_rdata_i;
    assign rom_wr_o           = host_wr_i;
    assign rom_wdata_o        = host_wdata_i;
    assign addr_err_o         = addr_err_q;
endmodule

// File: tb/tb_legendre_rom_arbiter.sv
// Bench for legendre_rom_arbiter: synchronous ROM model, per-scenario tasks checking grants
// inline, and a scoreboard of expected {data_valid, word} popped when data returns.
module tb_legendre_rom_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int MAX_WAIT = 2;
    localparam int EW       = NUM_REQ + 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rom_addr;
    logic        rom_rd;
    logic [15:0] rom_rdata;
    logic        host_wr;
    logic [9:0]  host_addr;
    logic [15:0] host_wdata;
    logic        rom_wr;
    logic [15:0] rom_wdata;
    logic        addr_err;

    logic [15:0]   rom_mem [1024];
    logic [9:0]    addr_r [NUM_REQ];
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] mon_exp;
    int            n_checks = 0;
    int            n_pass   = 0;

    legendre_rom_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    legendre_rom_arbiter #(.NUM_REQ(NUM_REQ), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rom_addr_o(rom_addr), .rom_rd_o(rom_rd), .rom_rdata_i(rom_rdata),
        .host_wr_i(host_wr), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .rom_wr_o(rom_wr), .rom_wdata_o(rom_wdata), .addr_err_o(addr_err)
    );

    // ---------------- clock / reset / ROM model ----------------
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [9:0] a);
        return {6'h15, a} ^ 16'h0A5A;
    endfunction

    always @(posedge clk) begin
        if (rom_wr) rom_mem[rom_addr] <= rom_wdata;
        if (rom_rd) rom_rdata <= rom_mem[rom_addr];
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        #2;
        if (!rst && bus.data_valid !== '0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_unexpected: data_valid=%b data=%h, nothing expected",
                         bus.data_valid, bus.legendre_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.data_valid, bus.legendre_data} !== mon_exp)
                    $display("FAIL scoreboard_data: got dv=%b data=%h, expected dv=%b data=%h",
                             bus.data_valid, bus.legendre_data,
                             mon_exp[EW-1:16], mon_exp[15:0]);
                else
                    n_pass++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_addr(input int i, input logic [9:0] a);
        addr_r[i] = a;
        bus.req_addr[i*10 +: 10] = a;
    endtask

    task automatic set_reqs(input logic [NUM_REQ-1:0] rd, input logic [NUM_REQ-1:0] pre);
        bus.req_rd      = rd;
        bus.req_preempt = pre;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_reqs('0, '0);
        host_wr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_reqs('1, '0);
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.req_read_valid, rom_rd} !== {4'b0000, 1'b0})
            $display("FAIL reset_forced: gnt=%b rd=%b, expected gnt=0000 rd=0", bus.req_read_valid, rom_rd);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        set_reqs('0, '0);
        #1;
        n_checks++;
        if ({bus.data_valid, addr_err, rom_addr, rom_rd} !== {4'b0000, 1'b0, 10'd0, 1'b0})
            $display("FAIL reset_state: dv=%b err=%b addr=%h rd=%b, expected 0000 0 000 0",
                     bus.data_valid, addr_err, rom_addr, rom_rd);
        else n_pass++;
    endtask

    task automatic test_single_read();
        do_reset();
        set_addr(2, 10'h123);
        @(negedge clk);
        set_reqs(4'b0100, '0);
        #1;
        n_checks++;
        if ({bus.req_read_valid, rom_rd, rom_addr} !== {4'b0100, 1'b1, 10'h123})
            $display("FAIL single_grant: gnt=%b rd=%b addr=%h, expected 0100 1 123",
                     bus.req_read_valid, rom_rd, rom_addr);
        else n_pass++;
        exp_q.push_back({4'b0100, rom_word(10'h123)});
        @(negedge clk);
        set_reqs('0, '0);
        #1;
        n_checks++;
        if ({bus.req_read_valid, rom_rd, rom_addr} !== {4'b0000, 1'b0, 10'h123})
            $display("FAIL idle_hold: gnt=%b rd=%b addr=%h, expected 0000 0 123",
                     bus.req_read_valid, rom_rd, rom_addr);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_t[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, 10'(i * 37 + 3));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_reqs(4'b1111, '0);
            #1;
            n_checks++;
            if ({bus.req_read_valid, rom_rd, rom_addr} !== {4'(1 << exp_t[k]), 1'b1, addr_r[exp_t[k]]})
                $display("FAIL round_robin step %0d: gnt=%b addr=%h, expected gnt=%b addr=%h",
                         k, bus.req_read_valid, rom_addr, 4'(1 << exp_t[k]), addr_r[exp_t[k]]);
            else n_pass++;
            exp_q.push_back({4'(1 << exp_t[k]), rom_word(addr_r[exp_t[k]])});
        end
    endtask

    task automatic test_preempt();
        logic [3:0] rd_t[3]  = '{4'b1011, 4'b0011, 4'b0010};
        logic [3:0] pre_t[3] = '{4'b1000, 4'b0000, 4'b0000};
        int         exp_t[3] = '{3, 0, 1};
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, 10'(100 + i * 11));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_reqs(rd_t[k], pre_t[k]);
            #1;
            n_checks++;
            if ({bus.req_read_valid, rom_rd, rom_addr} !== {4'(1 << exp_t[k]), 1'b1, addr_r[exp_t[k]]})
                $display("FAIL preempt step %0d: gnt=%b addr=%h, expected gnt=%b addr=%h",
                         k, bus.req_read_valid, rom_addr, 4'(1 << exp_t[k]), addr_r[exp_t[k]]);
            else n_pass++;
            exp_q.push_back({4'(1 << exp_t[k]), rom_word(addr_r[exp_t[k]])});
        end
    endtask

    task automatic test_starvation();
        int exp_t[3] = '{1, 2, 0};
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, 10'(200 + i));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_reqs(4'b0111, 4'b0110);
            #1;
            n_checks++;
            if ({bus.req_read_valid, rom_rd, rom_addr} !== {4'(1 << exp_t[k]), 1'b1, addr_r[exp_t[k]]})
                $display("FAIL starvation wait %0d: gnt=%b addr=%h, expected gnt=%b addr=%h",
                         k + 1, bus.req_read_valid, rom_addr, 4'(1 << exp_t[k]), addr_r[exp_t[k]]);
            else n_pass++;
            exp_q.push_back({4'(1 << exp_t[k]), rom_word(addr_r[exp_t[k]])});
        end
    endtask

    task automatic test_drop();
        do_reset();
        set_addr(0, 10'h2A0);
        set_addr(2, 10'h055);
        @(negedge clk);
        set_reqs(4'b0101, '0);
        #1;
        n_checks++;
        if ({bus.req_read_valid, rom_rd, rom_addr} !== {4'b0001, 1'b1, 10'h2A0})
            $display("FAIL drop_first: gnt=%b addr=%h, expected 0001 2a0", bus.req_read_valid, rom_addr);
        else n_pass++;
        exp_q.push_back({4'b0001, rom_word(10'h2A0)});
        @(negedge clk);
        set_reqs('0, '0);
        #1;
        n_checks++;
        if ({bus.req_read_valid, rom_rd, rom_addr} !== {4'b0000, 1'b0, 10'h2A0})
            $display("FAIL drop_ignored: gnt=%b rd=%b addr=%h, expected 0000 0 2a0",
                     bus.req_read_valid, rom_rd, rom_addr);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_addr(1, 10'(10'h040 + k));
            set_reqs(4'b0010, '0);
            #1;
            n_checks++;
            if ({bus.req_read_valid, rom_rd, rom_addr} !== {4'b0010, 1'b1, 10'(10'h040 + k)})
                $display("FAIL back_to_back step %0d: gnt=%b addr=%h, expected 0010 %h",
                         k, bus.req_read_valid, rom_addr, 10'(10'h040 + k));
            else n_pass++;
            exp_q.push_back({4'b0010, rom_word(10'(10'h040 + k))});
        end
    endtask

    task automatic test_host();
        do_reset();
        set_addr(0, 10'h3F1);
        for (int i = 1; i < NUM_REQ; i++) set_addr(i, 10'(i));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_reqs(4'b1111, '0);
            host_wr    = 1'b1;
            host_addr  = 10'(10'h3F0 + k);
            host_wdata = 16'(16'hBEE0 + k);
            #1;
            n_checks++;
            if ({bus.req_read_valid, rom_rd, rom_addr} !== {4'b0000, 1'b0, 10'(10'h3F0 + k)})
                $display("FAIL host_block step %0d: gnt=%b rd=%b addr=%h, expected 0000 0 %h",
                         k, bus.req_read_valid, rom_rd, rom_addr, 10'(10'h3F0 + k));
            else n_pass++;
            n_checks++;
            if ({rom_wr, rom_wdata} !== {1'b1, 16'(16'hBEE0 + k)})
                $display("FAIL host_write step %0d: wr=%b wdata=%h, expected 1 %h",
                         k, rom_wr, rom_wdata, 16'(16'hBEE0 + k));
            else n_pass++;
        end
        @(negedge clk);
        host_wr = 1'b0;
        set_reqs(4'b1111, '0);
        #1;
        n_checks++;
        if ({bus.req_read_valid, rom_rd, rom_addr, rom_wr} !== {4'b0001, 1'b1, 10'h3F1, 1'b0})
            $display("FAIL host_resume: gnt=%b rd=%b addr=%h wr=%b, expected 0001 1 3f1 0",
                     bus.req_read_valid, rom_rd, rom_addr, rom_wr);
        else n_pass++;
        exp_q.push_back({4'b0001, 16'hBEE1});
    endtask

    task automatic test_addr_err();
        do_reset();
        set_addr(0, 10'd640);
        set_addr(1, 10'd641);
        set_addr(2, 10'd5);
        @(negedge clk);
        set_reqs(4'b0001, '0);
        exp_q.push_back({4'b0001, rom_word(10'd640)});
        @(negedge clk);
        set_reqs('0, '0);
        #1;
        n_checks++;
        if (addr_err !== 1'b0) $display("FAIL addr_err_640: got %b, expected 0", addr_err);
        else n_pass++;
        @(negedge clk);
        set_reqs(4'b0010, '0);
        #1;
        n_checks++;
        if ({bus.req_read_valid, rom_rd, rom_addr} !== {4'b0010, 1'b1, 10'd641})
            $display("FAIL addr_err_read: gnt=%b addr=%0d, expected 0010 641", bus.req_read_valid, rom_addr);
        else n_pass++;
        exp_q.push_back({4'b0010, rom_word(10'd641)});
        @(negedge clk);
        set_reqs(4'b0100, '0);
        #1;
        n_checks++;
        if (addr_err !== 1'b1) $display("FAIL addr_err_set: got %b, expected 1", addr_err);
        else n_pass++;
        exp_q.push_back({4'b0100, rom_word(10'd5)});
        @(negedge clk);
        set_reqs('0, '0);
        #1;
        n_checks++;
        if (addr_err !== 1'b1) $display("FAIL addr_err_sticky: got %b, expected 1", addr_err);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({addr_err, bus.data_valid, rom_addr, rom_rd} !== {1'b0, 4'b0000, 10'd0, 1'b0})
            $display("FAIL addr_err_clear: err=%b dv=%b addr=%h rd=%b, expected 0 0000 000 0",
                     addr_err, bus.data_valid, rom_addr, rom_rd);
        else n_pass++;
    endtask

    task automatic test_reset_after_grant();
        do_reset();
        set_addr(0, 10'd7);
        @(negedge clk);
        set_reqs(4'b0001, '0);
        #1;
        n_checks++;
        if (bus.req_read_valid !== 4'b0001)
            $display("FAIL rag_grant: gnt=%b, expected 0001", bus.req_read_valid);
        else n_pass++;
        @(negedge clk);
        set_reqs(4'b0001, '0);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.data_valid, bus.req_read_valid, rom_rd} !== {4'b0000, 4'b0000, 1'b0})
            $display("FAIL rag_discard: dv=%b gnt=%b rd=%b, expected 0000 0000 0",
                     bus.data_valid, bus.req_read_valid, rom_rd);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        set_reqs('0, '0);
        #1;
        n_checks++;
        if (bus.data_valid !== 4'b0000)
            $display("FAIL rag_after: dv=%b, expected 0000", bus.data_valid);
        else n_pass++;
    endtask

    // ---------------- sequence / final report ----------------
    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = rom_word(10'(i));
        rom_rdata  = '0;
        host_wr    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        bus.req_addr = '0;
        set_reqs('0, '0);
        for (int i = 0; i < NUM_REQ; i++) addr_r[i] = '0;

        test_reset();
        test_single_read();
        test_round_robin();
        test_preempt();
        test_starvation();
        test_drop();
        test_back_to_back();
        test_host();
        test_addr_err();
        test_reset_after_grant();

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/legendre_rom_arbiter.md
LEGENDRE_ROM_ARBITER -- requirements
Module: m_legendre_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of Legendre read requesters (two per Weil PRN generator).
REQ-002 Parameter MAX_WAIT, default 8, cycles a normal request may wait before it is promoted to urgent.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_addr  input  10*NUM_REQ  requester i Legendre word address in bits [10i+9:10i]; valid range 0..640.
REQ-006 req_rd  input  NUM_REQ  requester i read request; held high until granted.
REQ-007 req_preempt  input  NUM_REQ  requester i urgent flag; its code register is about to run dry.
REQ-008 req_read_valid  output  NUM_REQ  combinational grant; one-hot or zero; bit i high only while req_rd[i] is high.
REQ-009 legendre_data  output  16  ROM read data; valid in the cycle after a grant.
REQ-010 data_valid  output  NUM_REQ  registered copy of req_read_valid; marks the cycle in which legendre_data belongs to requester i.
REQ-011 rom_addr  output  10  address to the synchronous ROM/RAM (1-cycle read latency).
REQ-012 rom_rd  output  1  ROM read enable.
REQ-013 rom_rdata  input  16  ROM read data; passed straight to legendre_data.
REQ-014 host_wr  input  1  host table write strobe.
REQ-015 host_addr  input  10  host write address.
REQ-016 host_wdata  input  16  host write data.
REQ-017 rom_wr  output  1  ROM write enable; equals host_wr.
REQ-018 rom_wdata  output  16  equals host_wdata.
REQ-019 addr_err  output  1  sticky flag; set when a granted address exceeds 640.

Function
REQ-020 At most one requester SHALL be granted per cycle; a grant consumes exactly one ROM read.
REQ-021 host_wr SHALL have absolute priority: while it is high, req_read_valid is all zero, rom_rd=0, and rom_addr=host_addr.
REQ-022 Request classes, highest first: (a) urgent = req_preempt[i] or wait_cnt[i]==MAX_WAIT; (b) normal.
REQ-023 Within a class, the winner SHALL be chosen round-robin, starting from the index after rr_ptr.
REQ-024 On a grant to index g: rr_ptr<=g; rom_rd=1; rom_addr=req_addr of g, same cycle.
REQ-025 When there is no grant: rom_rd=0 and rom_addr holds the last driven value (a register, reset 0).
REQ-026 wait_cnt[i] (width clog2(MAX_WAIT+1)) SHALL increment, saturating at MAX_WAIT, each cycle req_rd[i]=1 and i is not granted.
REQ-027 wait_cnt[i] SHALL clear when i is granted or when req_rd[i]=0.
REQ-028 data_valid SHALL equal req_read_valid delayed one cycle; legendre_data=rom_rdata combinationally.
REQ-029 A requester that drops req_rd before it is granted SHALL be ignored from that cycle; no data_valid is generated for it.
REQ-030 addr_err SHALL set on a grant with address >640; it clears only on rst; the read is still performed.
REQ-031 Back-to-back grants to the same requester in consecutive cycles are allowed when it is the only one requesting.

Reset
REQ-032 While rst=1, the following SHALL take these values on the next edge:
- rr_ptr=NUM_REQ-1
- all wait_cnt=0
- data_valid=0
- rom_addr register=0
- addr_err=0
REQ-033 While rst=1, req_read_valid and rom_rd SHALL be forced to 0.
REQ-034 Reset asserted in the cycle after a grant SHALL clear data_valid; that data is discarded.

Verification
REQ-035 Single read: req_rd[2]=1, addr=0x123 -> same cycle req_read_valid=0100, rom_addr=0x123, rom_rd=1; next cycle data_valid=0100 with ROM word 0x123.
REQ-036 All four requesting, no preempt, from reset -> grants in order 0,1,2,3,0 on consecutive cycles.
REQ-037 req 0,1 normal and req 3 preempt in the same cycle -> 3 granted first, then 0, then 1.
REQ-038 Starvation, MAX_WAIT=2: req 0 normal; req 1 and 2 preempt and re-request continuously.
- Required: req 0 granted no later than its 3rd waiting cycle.
REQ-039 host_wr=1 for 3 cycles with req_rd=1111 -> no grants, rom_wr=1, rom_addr=host_addr; grants resume the cycle after.
REQ-040 Grant with addr=641 -> addr_err=1 and stays set through further reads; rst pulse clears it and all outputs.
